// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the native memory bus arbiter.
package mem_bus_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic MST_CORE = 1'b0;
    localparam logic MST_DMA  = 1'b1;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;
    localparam int MEM_SW = 4;
endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a valid/ready native memory port, grant locked per transaction.
// One IDLE cycle of arbitration latency; masters stall on their own valid until ready, watchdog forces completion.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_valid,
    input  logic [MEM_AW-1:0] m0_addr,
    input  logic [MEM_DW-1:0] m0_wdata,
    input  logic [MEM_SW-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [MEM_DW-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic [MEM_AW-1:0] m1_addr,
    input  logic [MEM_DW-1:0] m1_wdata,
    input  logic [MEM_SW-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [MEM_DW-1:0] m1_rdata,
    output logic              s_valid,
    output logic [MEM_AW-1:0] s_addr,
    output logic [MEM_DW-1:0] s_wdata,
    output logic [MEM_SW-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic [MEM_DW-1:0] s_rdata,
    output logic              grant,
    output logic              busy,
    output logic              timeout_err
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t             state, state_nxt;
    logic               grant_nxt;
    logic               last, last_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic               in_busy;
    logic               gvalid;
    logic               wd_hit;
    logic               done;
    logic [MEM_DW-1:0]  done_data;

    assign in_busy = (state == ST_BUSY);
    assign gvalid  = (grant == MST_DMA) ? m1_valid : m0_valid;
    assign wd_hit  = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    assign done    = in_busy && gvalid && (s_ready || wd_hit);

    // Normal completion beats the watchdog when both land in the same cycle.
    assign done_data = s_ready ? s_rdata : ERR_RDATA;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= MST_CORE;
            last  <= MST_DMA;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    if (m0_valid && m1_valid) grant_nxt = ~last;
                    else                      grant_nxt = m1_valid ? MST_DMA : MST_CORE;
                    state_nxt = ST_BUSY;
                    cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                // A dropped valid is an abort: no ready, fairness history untouched.
                if (!gvalid) begin
                    state_nxt = ST_IDLE;
                end else if (done) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = grant;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request is withdrawn from the slave in the watchdog cycle.
    assign s_valid     = in_busy && gvalid && !wd_hit;
    assign s_addr      = (grant == MST_DMA) ? m1_addr  : m0_addr;
    assign s_wdata     = (grant == MST_DMA) ? m1_wdata : m0_wdata;
    assign s_wstrb     = (grant == MST_DMA) ? m1_wstrb : m0_wstrb;
    assign busy        = in_busy;
    assign timeout_err = in_busy && gvalid && wd_hit && !s_ready;

    assign m0_ready = done && (grant == MST_CORE);
    assign m1_ready = done && (grant == MST_DMA);
    assign m0_rdata = m0_ready ? done_data : '0;
    assign m1_rdata = m1_ready ? done_data : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a 16-cycle watchdog.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        grant, busy, timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter #(.TIMEOUT(16), .ERR_RDATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Per-transaction expectations for the alternation run.
    logic        exp_g  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        // Reset state
        do_reset();
        smp();
        check_val("rst_s_valid", s_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_grant", grant, 0);
        check_val("rst_m0_ready", m0_ready, 0);
        check_val("rst_m1_rdata", m1_rdata, 0);
        check_val("rst_tmo", timeout_err, 0);

        // 1: single m0 read, slave ready on third BUSY cycle
        tick();
        m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
        smp();
        check_val("t1_idle_s_valid", s_valid, 0);
        tick();
        smp();
        check_val("t1_s_valid", s_valid, 1);
        check_val("t1_s_addr", s_addr, 32'h0000_0100);
        check_val("t1_busy", busy, 1);
        check_val("t1_m0_ready_early", m0_ready, 0);
        tick();
        tick();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        smp();
        check_val("t1_m0_ready", m0_ready, 1);
        check_val("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        check_val("t1_m1_ready", m1_ready, 0);
        check_val("t1_m1_rdata", m1_rdata, 0);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        smp();
        check_val("t1_after_ready", m0_ready, 0);
        check_val("t1_after_busy", busy, 0);

        // 2: simultaneous requests after reset
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0200; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h0000_0300; m1_wstrb = 4'hF; m1_wdata = 32'h5555_AAAA;
        smp();
        check_val("t2_idle_s_valid", s_valid, 0);
        tick();
        s_ready = 1'b1; s_rdata = 32'h0000_00A0;
        smp();
        check_val("t2_grant0", grant, 0);
        check_val("t2_s_addr0", s_addr, 32'h0000_0200);
        check_val("t2_m0_ready", m0_ready, 1);
        check_val("t2_m1_ready0", m1_ready, 0);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        smp();
        check_val("t2_gap_s_valid", s_valid, 0);
        check_val("t2_gap_busy", busy, 0);
        tick();
        s_ready = 1'b1; s_rdata = 32'h0000_00B1;
        smp();
        check_val("t2_grant1", grant, 1);
        check_val("t2_s_wstrb1", s_wstrb, 4'hF);
        check_val("t2_s_wdata1", s_wdata, 32'h5555_AAAA);
        check_val("t2_m1_ready", m1_ready, 1);
        check_val("t2_m1_rdata", m1_rdata, 32'h0000_00B1);
        check_val("t2_m0_ready1", m0_ready, 0);
        tick();
        m1_valid = 1'b0; s_ready = 1'b0;

        // 3: m0 streams writes while m1 keeps requesting -> strict alternation
        m0_valid = 1'b1; m0_wstrb = 4'h3;
        m1_valid = 1'b1; m1_wstrb = 4'hC; m1_wdata = 32'hD0D0_0001;
        for (int i = 0; i < 5; i++) begin
            m0_wdata = 32'hA000_0000 + i;
            s_ready = 1'b0;
            smp();
            check_val($sformatf("t3_idle_%0d", i), busy, 0);
            tick();
            s_ready = 1'b1; s_rdata = 32'h0000_0C00 + i;
            smp();
            check_val($sformatf("t3_grant_%0d", i), grant, exp_g[i]);
            check_val($sformatf("t3_wdata_%0d", i), s_wdata,
                      exp_g[i] ? 32'hD0D0_0001 : (32'hA000_0000 + i));
            check_val($sformatf("t3_wstrb_%0d", i), s_wstrb, exp_g[i] ? 4'hC : 4'h3);
            check_val($sformatf("t3_ready_%0d", i), exp_g[i] ? m1_ready : m0_ready, 1);
            check_val($sformatf("t3_other_%0d", i), exp_g[i] ? m0_ready : m1_ready, 0);
            tick();
        end
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;

        // 4: slave never readies -> watchdog on 16th BUSY cycle
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0400; m0_wstrb = 4'h0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            smp();
            check_val($sformatf("t4_wait_rdy_%0d", c), m0_ready, 0);
            check_val($sformatf("t4_wait_tmo_%0d", c), timeout_err, 0);
        end
        tick();
        smp();
        check_val("t4_m0_ready", m0_ready, 1);
        check_val("t4_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check_val("t4_tmo", timeout_err, 1);
        check_val("t4_s_valid", s_valid, 0);
        tick();
        m0_valid = 1'b0;
        smp();
        check_val("t4_busy_after", busy, 0);
        check_val("t4_tmo_after", timeout_err, 0);

        // 5: s_ready coincides with the watchdog cycle
        m0_valid = 1'b1; m0_addr = 32'h0000_0500;
        for (int c = 1; c <= 15; c++) tick();
        tick();
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        smp();
        check_val("t5_m0_ready", m0_ready, 1);
        check_val("t5_m0_rdata", m0_rdata, 32'hCAFE_F00D);
        check_val("t5_tmo", timeout_err, 0);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;

        // 6: reset while BUSY with m1
        m1_valid = 1'b1; m1_addr = 32'h0000_0600;
        tick();
        tick();
        smp();
        check_val("t6_grant1", grant, 1);
        check_val("t6_s_valid_pre", s_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_s_valid_rst", s_valid, 0);
        check_val("t6_busy_rst", busy, 0);
        check_val("t6_grant_rst", grant, 0);
        tick();
        rst = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0000_0700;
        smp();
        check_val("t6_idle_s_valid", s_valid, 0);
        tick();
        smp();
        check_val("t6_grant_after", grant, 0);
        check_val("t6_s_addr_after", s_addr, 32'h0000_0700);
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
